// File: rtl/instr_feeder.sv
// instr_feeder: fetch/issue stage between program ROM and the 16-bit core.
// It walks the ROM from PC=0 and presents each word on DIN with a one-cycle
// Run pulse. It waits for Done from the core before fetching the next word,
// and stops on HALT_WORD or after word PROG_LEN-1.
// Optional build macro FEEDER_WATCHDOG_EN adds a Done watchdog. If it expires,
// the block sets Err and halts. Without the macro, Err is constant 0.
// Handshake: Run is a one-cycle strobe raised only in ISSUE. DIN is stable
// from ISSUE until Done is seen. Done is accepted only in WAIT_DONE; in any
// other state (including the ISSUE cycle) it is ignored. Start is accepted
// only in IDLE or HALT.
module instr_feeder #(
  parameter int          ADDR_W    = 8,
  parameter int          PROG_LEN  = 256,
  parameter logic [15:0] HALT_WORD = 16'hE000,
  parameter int          TIMEOUT   = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [ADDR_W-1:0] Mem_addr,
  input  logic [15:0]       Mem_q,
  output logic [15:0]       DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [2:0]        Fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  // The end-of-program check is made before the increment, so PC never wraps.
  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_LEN - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       din_q, din_d;

`ifdef FEEDER_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  // State, PC and instruction registers, all with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      din_q   <= '0;
`ifdef FEEDER_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
`ifdef FEEDER_WATCHDOG_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: fetch, latch, issue, then wait for the core.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    din_d   = din_q;
`ifdef FEEDER_WATCHDOG_EN
    err_d   = err_q;
    // The counter runs only in WAIT_DONE, so it is zero on entry.
    wd_d    = (state_q == S_WAIT_DONE) ? wd_q + 1'b1 : '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        // The halt word is captured too, but it is never issued.
        din_d   = Mem_q;
        state_d = (Mem_q == HALT_WORD) ? S_HALT : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (Done) begin
          if (pc_q == LAST_PC) begin
            state_d = S_HALT;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end
`ifdef FEEDER_WATCHDOG_EN
        else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // Stalled core: keep PC at the hung instruction for post-mortem.
          err_d   = 1'b1;
          state_d = S_HALT;
        end
`endif
      end
      S_HALT: begin
        if (Start) begin
          state_d = S_FETCH;
          pc_d    = '0;
`ifdef FEEDER_WATCHDOG_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign Mem_addr  = pc_q;
  assign PC        = pc_q;
  assign DIN       = din_q;
  assign Run       = (state_q == S_ISSUE);
  assign Busy      = (state_q != S_IDLE) && (state_q != S_HALT);
  assign Halted    = (state_q == S_HALT);
  assign Fsm_state = state_q;

`ifdef FEEDER_WATCHDOG_EN
  assign Err = err_q;
`else
  // TIMEOUT only has meaning with the watchdog. It is referenced here so the
  // parameter stays part of the interface; the expression is constant 0.
  localparam logic TIMEOUT_SET = (TIMEOUT > 0);
  assign Err = 1'b0 & TIMEOUT_SET;
`endif

endmodule
